// File: rtl/rmon_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rmon_rd_pkg
// Purpose  : Shared types and constants for the RMON counter read arbiter:
//            FSM state encoding, requester owner codes and default widths.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package rmon_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } rd_state_e;

  localparam logic OWN_H = 1'b0;
  localparam logic OWN_P = 1'b1;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/rmon_rd_rr2.sv
`default_nettype none
// ============================================================================
// Module   : rmon_rd_rr2
// Purpose  : Combinational two-way round-robin select. A lone requester wins;
//            when both request, the one that was not served last wins.
// Ports    : h_req, p_req   - request inputs
//            last_served    - owner code of the previously served requester
//            grant_valid    - at least one request present
//            grant_owner    - winning owner code (OWN_H / OWN_P)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module rmon_rd_rr2
  import rmon_rd_pkg::*;
(
  input  logic h_req,
  input  logic p_req,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = h_req | p_req;
    if (h_req && p_req) begin
      grant_owner = ~last_served;
    end else if (p_req) begin
      grant_owner = OWN_P;
    end else begin
      grant_owner = OWN_H;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rmon_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rmon_rd_arbiter
// Purpose  : Shares the RMON counter read port between the host register
//            path (H) and the statistics poll engine (P). Runs the four-phase
//            apply/grant handshake, captures the read data and returns it to
//            the winning requester with a one-cycle ack pulse.
// Ports    : Clk_reg, Reset (async, active low)
//            H_req/H_addr -> H_ack/H_err/H_data   host requester
//            P_req/P_addr -> P_ack/P_err/P_data   poll requester
//            CPU_rd_addr/CPU_rd_apply -> RMON, CPU_rd_grant/CPU_rd_dout <- RMON
//            Busy_o  - FSM not idle
//            Owner_o - current or last owner (0 = H, 1 = P)
// Options  : RMON_RD_TIMEOUT_EN - enables the grant timeout counter and the
//            H_err / P_err flags; when undefined APPLY waits forever for grant
//            and both err outputs are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module rmon_rd_arbiter
  import rmon_rd_pkg::*;
#(
  parameter int              ADDR_W  = DEF_ADDR_W,
  parameter int              DATA_W  = DEF_DATA_W,
  parameter int              TO_W    = 8,
  parameter logic [TO_W-1:0] TIMEOUT = 8'd200
) (
  input  logic              Clk_reg,
  input  logic              Reset,
  input  logic              H_req,
  input  logic [ADDR_W-1:0] H_addr,
  output logic              H_ack,
  output logic              H_err,
  output logic [DATA_W-1:0] H_data,
  input  logic              P_req,
  input  logic [ADDR_W-1:0] P_addr,
  output logic              P_ack,
  output logic              P_err,
  output logic [DATA_W-1:0] P_data,
  output logic [ADDR_W-1:0] CPU_rd_addr,
  output logic              CPU_rd_apply,
  input  logic              CPU_rd_grant,
  input  logic [DATA_W-1:0] CPU_rd_dout,
  output logic              Busy_o,
  output logic              Owner_o
);

  rd_state_e         state_q, state_d;
  logic              apply_q, apply_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] h_data_q, h_data_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              h_ack_q, h_ack_d;
  logic              p_ack_q, p_ack_d;

  logic              arb_valid;
  logic              arb_owner;

  // Requests only matter in IDLE, so the selector sees raw requests.
  rmon_rd_rr2 u_rr2 (
    .h_req       (H_req),
    .p_req       (P_req),
    .last_served (last_q),
    .grant_valid (arb_valid),
    .grant_owner (arb_owner)
  );

`ifdef RMON_RD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tout_q, tout_d;
  logic            h_err_q, h_err_d;
  logic            p_err_q, p_err_d;
`else
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    apply_d  = apply_q;
    addr_d   = addr_q;
    owner_d  = owner_q;
    last_d   = last_q;
    h_data_d = h_data_q;
    p_data_d = p_data_q;
    h_ack_d  = 1'b0;
    p_ack_d  = 1'b0;
`ifdef RMON_RD_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    tout_d   = tout_q;
    h_err_d  = 1'b0;
    p_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_APPLY;
          apply_d = 1'b1;
          owner_d = arb_owner;
          addr_d  = (arb_owner == OWN_P) ? P_addr : H_addr;
`ifdef RMON_RD_TIMEOUT_EN
          to_cnt_d = '0;
          tout_d   = 1'b0;
`endif
        end
      end

      ST_APPLY: begin
        // Grant takes precedence over a timeout landing in the same cycle.
        if (CPU_rd_grant) begin
          state_d = ST_ACK;
          apply_d = 1'b0;
          if (owner_q == OWN_P) begin
            p_data_d = CPU_rd_dout;
          end else begin
            h_data_d = CPU_rd_dout;
          end
`ifdef RMON_RD_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          // Counter started at 0 in the first APPLY cycle, so apply has
          // been high for exactly TIMEOUT cycles here.
          state_d = ST_ACK;
          apply_d = 1'b0;
          tout_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_ACK: begin
        // Ack/err are registered, so they appear during the next state.
        h_ack_d = (owner_q == OWN_H);
        p_ack_d = (owner_q == OWN_P);
`ifdef RMON_RD_TIMEOUT_EN
        h_err_d = (owner_q == OWN_H) & tout_q;
        p_err_d = (owner_q == OWN_P) & tout_q;
`endif
        last_d  = owner_q;
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Closing phase of the handshake: RMON must drop grant first.
        if (!CPU_rd_grant) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        apply_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_reg or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      apply_q  <= 1'b0;
      addr_q   <= '0;
      owner_q  <= OWN_H;
      last_q   <= OWN_P;  // H wins the first contest after reset
      h_data_q <= '0;
      p_data_q <= '0;
      h_ack_q  <= 1'b0;
      p_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      apply_q  <= apply_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      h_data_q <= h_data_d;
      p_data_q <= p_data_d;
      h_ack_q  <= h_ack_d;
      p_ack_q  <= p_ack_d;
    end
  end

`ifdef RMON_RD_TIMEOUT_EN
  always_ff @(posedge Clk_reg or negedge Reset) begin
    if (!Reset) begin
      to_cnt_q <= '0;
      tout_q   <= 1'b0;
      h_err_q  <= 1'b0;
      p_err_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tout_q   <= tout_d;
      h_err_q  <= h_err_d;
      p_err_q  <= p_err_d;
    end
  end

  assign H_err = h_err_q;
  assign P_err = p_err_q;
`else
  assign H_err = 1'b0;
  assign P_err = 1'b0;
`endif

  assign H_ack        = h_ack_q;
  assign P_ack        = p_ack_q;
  assign H_data       = h_data_q;
  assign P_data       = p_data_q;
  assign CPU_rd_addr  = addr_q;
  assign CPU_rd_apply = apply_q;
  assign Owner_o      = owner_q;
  assign Busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rmon_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmon_rd_arbiter
// Purpose  : Self-checking bench for rmon_rd_arbiter. Drives directed and
//            randomized read transactions, plays the RMON side of the
//            handshake, and compares against a round-robin reference model.
// Options  : RMON_RD_TIMEOUT_EN - selects the timeout scenario instead of the
//            long-grant-delay scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmon_rd_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TOUT = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_req = 1'b0, p_req = 1'b0;
  logic [AW-1:0] h_addr = '0, p_addr = '0;
  logic          h_ack, h_err, p_ack, p_err;
  logic [DW-1:0] h_data, p_data;
  logic [AW-1:0] rd_addr;
  logic          rd_apply;
  logic          rd_grant = 1'b0;
  logic [DW-1:0] rd_dout = '0;
  logic          busy, owner;

  always #5 clk = ~clk;

  rmon_rd_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TO_W   (8),
    .TIMEOUT(8'd200)
  ) dut (
    .Clk_reg      (clk),
    .Reset        (rst_n),
    .H_req        (h_req),
    .H_addr       (h_addr),
    .H_ack        (h_ack),
    .H_err        (h_err),
    .H_data       (h_data),
    .P_req        (p_req),
    .P_addr       (p_addr),
    .P_ack        (p_ack),
    .P_err        (p_err),
    .P_data       (p_data),
    .CPU_rd_addr  (rd_addr),
    .CPU_rd_apply (rd_apply),
    .CPU_rd_grant (rd_grant),
    .CPU_rd_dout  (rd_dout),
    .Busy_o       (busy),
    .Owner_o      (owner)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who was served last, and what each requester holds.
  bit            m_last;
  logic [DW-1:0] m_hdata, m_pdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_hdata = '0;
    m_pdata = '0;
  endtask

  // One full read transaction. Requests drop right after arbitration
  // (allowed: no abort). Grant rises after gdelay APPLY cycles and stays up
  // ghold cycles after the capture edge. early_h raises H_req during
  // RELEASE to show it is not applied before the FSM returns to idle.
  task automatic txn(input bit hr, input bit pr, input logic [AW-1:0] ha,
                     input logic [AW-1:0] pa, input int gdelay, input int ghold,
                     input logic [DW-1:0] dv, input bit early_h);
    bit            own;
    logic [AW-1:0] exp_addr;
    int            jexit;
    own      = (hr && pr) ? !m_last : pr;
    exp_addr = own ? pa : ha;
    @(negedge clk);
    h_req = hr; p_req = pr; h_addr = ha; p_addr = pa; rd_grant = 1'b0;
    @(posedge clk); #1;
    check("apply_rise", rd_apply, 1);
    check("rd_addr", rd_addr, exp_addr);
    check("owner", owner, own);
    check("busy_apply", busy, 1);
    @(negedge clk);
    h_req = 1'b0; p_req = 1'b0;
    for (int k = 0; k < gdelay; k++) begin
      @(posedge clk); #1;
      check("apply_wait", rd_apply, 1);
      check("ack_wait", {h_ack, p_ack}, 0);
      @(negedge clk);
    end
    rd_grant = 1'b1; rd_dout = dv;
    @(posedge clk); #1;
    if (own) m_pdata = dv; else m_hdata = dv;
    check("apply_fall", rd_apply, 0);
    check("cap_h_data", h_data, m_hdata);
    check("cap_p_data", p_data, m_pdata);
    check("ack_early", {h_ack, p_ack}, 0);
    jexit = (ghold + 2 > 3) ? ghold + 2 : 3;
    for (int j = 2; j <= jexit; j++) begin
      @(negedge clk);
      rd_grant = ((j - 2) < ghold);
      rd_dout  = $urandom;
      if (j >= 3 && early_h) begin
        h_req  = 1'b1;
        h_addr = AW'($urandom);
      end
      @(posedge clk); #1;
      check("h_ack", h_ack, (j == 2) && !own);
      check("p_ack", p_ack, (j == 2) && own);
      check("err", {h_err, p_err}, 0);
      check("busy_rel", busy, j < jexit);
      check("apply_rel", rd_apply, 0);
      check("hold_h_data", h_data, m_hdata);
      check("hold_p_data", p_data, m_pdata);
    end
    m_last = own;
  endtask

  initial begin
    bit prev_early;
    model_reset();
    #1;
    check("rst_outs", {h_ack, h_err, p_ack, p_err, rd_apply, busy, owner}, 0);
    check("rst_data", {h_data, p_data}, 0);
    check("rst_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single host read.
    txn(1'b1, 1'b0, 6'h05, 6'h00, 0, 0, 32'hDEADBEEF, 1'b0);

    // Reset during APPLY: apply drops asynchronously, no ack.
    @(negedge clk);
    p_req = 1'b1; p_addr = 6'h11;
    @(posedge clk); #1;
    check("apply_pre_rst", rd_apply, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_apply", rd_apply, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {h_ack, p_ack}, 0);
    check("rst_hdata", h_data, 0);
    model_reset();
    p_req = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_ack", {h_ack, p_ack, rd_apply}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests: H, P, H.
    txn(1'b1, 1'b1, 6'h01, 6'h02, 1, 0, $urandom, 1'b0);
    txn(1'b1, 1'b1, 6'h01, 6'h02, 0, 1, $urandom, 1'b0);
    txn(1'b1, 1'b1, 6'h01, 6'h02, 2, 0, $urandom, 1'b0);

    // Grant held 4 cycles after capture with H waiting; then H is served.
    txn(1'b0, 1'b1, 6'h00, 6'h2A, 0, 4, $urandom, 1'b1);
    txn(1'b1, 1'b0, h_addr, 6'h00, 0, 0, $urandom, 1'b0);

    // Grant in IDLE with no apply is ignored.
    @(negedge clk);
    rd_grant = 1'b1; rd_dout = 32'hA5A5_5A5A;
    repeat (2) @(posedge clk);
    #1;
    check("idle_grant_busy", busy, 0);
    check("idle_grant_data", {h_data, p_data}, {m_hdata, m_pdata});
    check("idle_grant_ack", {h_ack, p_ack, rd_apply}, 0);
    @(negedge clk);
    rd_grant = 1'b0;

`ifdef RMON_RD_TIMEOUT_EN
    // Poll read with no grant: apply for exactly TIMEOUT cycles, then err.
    @(negedge clk);
    p_req = 1'b1; p_addr = 6'h33;
    @(posedge clk); #1;
    check("to_apply0", rd_apply, 1);
    @(negedge clk);
    p_req = 1'b0;
    for (int k = 1; k < TOUT; k++) begin
      @(posedge clk); #1;
      check("to_apply", rd_apply, 1);
    end
    @(posedge clk); #1;
    check("to_apply_end", rd_apply, 0);
    check("to_busy", busy, 1);
    check("to_ack_early", p_ack, 0);
    @(posedge clk); #1;
    check("to_p_ack", p_ack, 1);
    check("to_p_err", p_err, 1);
    check("to_h", {h_ack, h_err}, 0);
    check("to_p_data", p_data, m_pdata);
    m_last = 1'b1;
    @(posedge clk); #1;
    check("to_idle", {busy, p_ack, p_err}, 0);
`else
    // Without timeout, a very late grant still completes cleanly.
    txn(1'b0, 1'b1, 6'h00, 6'h3C, 1000, 0, 32'h1234_5678, 1'b0);
`endif

    // Randomized traffic.
    prev_early = 1'b0;
    for (int n = 0; n < 30; n++) begin
      bit hr, pr, eh;
      hr = prev_early ? 1'b1 : 1'($urandom);
      pr = 1'($urandom);
      if (!hr && !pr) pr = 1'b1;
      eh = 1'($urandom);
      txn(hr, pr, prev_early ? h_addr : AW'($urandom), AW'($urandom),
          $urandom_range(0, 5), $urandom_range(0, 4), $urandom, eh);
      prev_early = eh;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
